// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: pixel/window widths, default frame
// geometry and the window-generator state encoding.
package sobel_pkg;

    localparam int PIXEL_W        = 8;
    localparam int WIN_PIXELS     = 9;
    localparam int WIN_W          = WIN_PIXELS * PIXEL_W;
    localparam int DEFAULT_WIDTH  = 720;
    localparam int DEFAULT_HEIGHT = 540;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage. The read is combinational at the same address
// as the write, so a read in a write cycle returns the value from the previous line.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_WIDTH,
    parameter int DWIDTH = PIXEL_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    always_ff @(posedge clock) begin
        if (en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window.sv
// Raster pixel stream in, one packed 3x3 window per interior pixel out.
// Two line buffers supply the rows above; two column taps supply the columns to the left.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int HEIGHT     = DEFAULT_HEIGHT,
    parameter int DWIDTH_IN  = PIXEL_W,
    parameter int DWIDTH_OUT = WIN_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH_IN-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH_OUT-1:0] out_data
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    state_e                       state_q, state_d;
    logic                         out_valid_q, out_valid_d;
    logic [DWIDTH_OUT-1:0]        out_data_q, out_data_d;
    logic [2:0][DWIDTH_IN-1:0]    tap1_q, tap1_d;
    logic [2:0][DWIDTH_IN-1:0]    tap2_q, tap2_d;
    logic [2:0][DWIDTH_IN-1:0]    new_col;
    logic [DWIDTH_IN-1:0]         lb0_rd, lb1_rd;
    logic                         accept;
    logic                         taken;
    logic                         line_end;

    assign in_ready = ~reset & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign taken    = out_valid_q & out_ready;
    assign line_end = (col_q == COL_LAST);

    // Index 0 is the oldest row (two lines up), index 2 the incoming pixel.
    assign new_col = {in_data, lb0_rd, lb1_rd};

    sobel_line_buffer #(.DEPTH(WIDTH), .DWIDTH(DWIDTH_IN)) u_lb0 (
        .clock   (clock),
        .en      (accept),
        .addr    (col_q),
        .wr_data (in_data),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(WIDTH), .DWIDTH(DWIDTH_IN)) u_lb1 (
        .clock   (clock),
        .en      (accept),
        .addr    (col_q),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        state_d     = state_q;
        tap1_d      = tap1_q;
        tap2_d      = tap2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (taken) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            tap2_d = tap1_q;
            tap1_d = new_col;

            if (line_end) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (state_q == FILL) begin
                if (line_end && row_q == RW'(1)) begin
                    state_d = RUN;
                end
            end else begin
                if (line_end && row_q == ROW_LAST) begin
                    state_d = FILL;
                end
            end

            // Taps hold the previous row's tail at col 0/1, so only col>=2 forms a window.
            if (state_q == RUN && col_q >= CW'(2)) begin
                out_valid_d = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    out_data_d[(r*3 + 0)*DWIDTH_IN +: DWIDTH_IN] = tap2_q[r];
                    out_data_d[(r*3 + 1)*DWIDTH_IN +: DWIDTH_IN] = tap1_q[r];
                    out_data_d[(r*3 + 2)*DWIDTH_IN +: DWIDTH_IN] = new_col[r];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            state_q     <= FILL;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clock) begin
        tap1_q <= tap1_d;
        tap2_q <= tap2_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
